word_serializer: RTL and testbench
==================================

// Module: word_serializer
// PURPOSE
//  Parallel-to-serial front end for the bit shift-register FIFO. Accepts LW-bit
//  words over a valid/ready handshake and emits them LSB-first, one bit per
//  i_ce, as a registered bit plus a strobe (o_ce) that drives the FIFO's i_in/i_ce.
//  A one-word holding register lets back-to-back words stream with no idle bit.
// PARAMETERS
//  LW          8   word width in bits (LW >= 2)
//  OPT_PARITY  0   1: append an even-parity bit after the word MSB
// PORTS
//  i_clk     in   1   system clock; all state on posedge
//  i_reset   in   1   asynchronous, active-high reset
//  i_stb     in   1   upstream word valid
//  i_word    in   LW  upstream word, sampled when i_stb && o_ready
//  o_ready   out  1   holding register empty; word accepted this edge if i_stb
//  i_ce      in   1   downstream bit-rate enable; one bit emitted per i_ce
//  o_ce      out  1   registered strobe: o_bit valid this cycle (feeds FIFO i_ce)
//  o_bit     out  1   serial data (feeds FIFO i_in)
//  o_last    out  1   high with o_ce on the final bit of a frame
//  o_idle    out  1   no word held and no word being shifted
// BEHAVIOUR
//  Reset (async): o_ready=1, o_ce=0, o_bit=0, o_last=0, o_idle=1, state IDLE,
//   hold empty, bit counter 0. Reset mid-word discards held and shifting words.
//  Handshake: accept on edge with i_stb && o_ready -> hold_valid=1, o_ready=0.
//   o_ready registered = !hold_valid; i_word ignored when not accepted.
//  Frame length NB = LW + OPT_PARITY. Counter width $clog2(NB).
//  States: IDLE, SHIFT, PARITY (PARITY only when OPT_PARITY=1).
//   IDLE: if hold_valid -> load sreg<=hold, par<=^hold, cnt<=0, hold empties,
//         -> SHIFT. Load is independent of i_ce.
//   SHIFT on i_ce: o_bit<=sreg[0], o_ce<=1, sreg>>=1, cnt++.
//     on bit cnt==LW-1: OPT_PARITY ? -> PARITY : end-of-frame.
//   PARITY on i_ce: o_bit<=par, o_ce<=1, end-of-frame.
//   End-of-frame edge: o_last<=1; if hold_valid load hold in same edge and go
//    to SHIFT (no gap), else -> IDLE.
//  Cycles without i_ce in SHIFT/PARITY: state frozen, o_ce=0, o_last=0,
//   o_bit holds last emitted value.
//  o_ce/o_last are single-cycle pulses; never high unless i_ce was high on the
//   preceding edge.
//  Latency (i_ce=1): accept edge E0, load edge E1, first bit o_ce after E2.
//  Simultaneous accept + load on same edge impossible (accept needs hold empty,
//   load needs hold full); hold refills while shifting, giving NB-cycle window.
//  o_idle = state==IDLE && !hold_valid, registered.
//  Parity: even, over the LW data bits only.
// TESTING
//  1. LW=8, i_word=8'hA5 once, i_ce=1 -> o_bit 1,0,1,0,0,1,0,1 on 8
//     consecutive o_ce, o_last on 8th, o_idle=1 one cycle later.
//  2. 8'h01 then 8'h80 offered back-to-back, i_ce=1 -> 16 contiguous o_ce,
//     bits 1,0x7 then 0x7,1; o_last on 8th and 16th; no gap.
//  3. 8'h3C, i_ce high every 3rd cycle -> o_ce exactly 1 cycle after each
//     i_ce, bits 0,0,1,1,1,1,0,0; o_bit stable between pulses.
//  4. OPT_PARITY=1, 8'h07 -> 1,1,1,0,0,0,0,0 then parity 1, o_last on 9th;
//     8'h03 -> parity 0.
//  5. i_stb held high with i_ce=0 -> 1st word loads, 2nd held, o_ready=0;
//     3rd not accepted until 1st frame ends; no word lost or duplicated.
//  6. Assert i_reset after 3 bits of 8'hFF -> outputs reset immediately
//     (before next edge); after release, next word emitted fully, no residue.

Source files
------------

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: LW-bit words in over valid/ready, LSB-first bits out
// one per i_ce, with an optional even-parity bit and a one-word holding register.
module word_serializer #(
    parameter int LW         = 8,
    parameter int OPT_PARITY = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_stb,
    input  logic [LW-1:0] i_word,
    output logic          o_ready,
    input  logic          i_ce,
    output logic          o_ce,
    output logic          o_bit,
    output logic          o_last,
    output logic          o_idle
);
    localparam int NB = LW + OPT_PARITY;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_DATA = CW'(LW - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t        state;
    logic [LW-1:0] hold;
    logic [LW-1:0] sreg;
    logic          par;
    logic          hold_valid;
    logic          hold_valid_next;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last_data;
    logic          frame_end;
    logic          load;

    always_comb begin
        accept    = i_stb && o_ready;
        last_data = (state == SHIFT) && i_ce && (cnt == LAST_DATA);
        frame_end = (last_data && (OPT_PARITY == 0)) || ((state == PARITY) && i_ce);
        // A held word is loaded either from IDLE or on the closing edge of a frame, so frames abut.
        load      = hold_valid && ((state == IDLE) || frame_end);
        hold_valid_next = hold_valid;
        if (accept) begin
            hold_valid_next = 1'b1;
        end else if (load) begin
            hold_valid_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
            cnt        <= '0;
            o_ready    <= 1'b1;
            o_ce       <= 1'b0;
            o_bit      <= 1'b0;
            o_last     <= 1'b0;
            o_idle     <= 1'b1;
        end else begin
            o_ce       <= 1'b0;
            o_last     <= frame_end;
            hold_valid <= hold_valid_next;
            o_ready    <= !hold_valid_next;
            o_idle     <= (state == IDLE) && !hold_valid;
            if (state == SHIFT && i_ce) begin
                o_bit <= sreg[0];
                o_ce  <= 1'b1;
                cnt   <= cnt + 1'b1;
            end else if (state == PARITY && i_ce) begin
                o_bit <= par;
                o_ce  <= 1'b1;
            end
            if (load) begin
                cnt   <= '0;
                state <= SHIFT;
            end else if (frame_end) begin
                state <= IDLE;
            end else if (last_data) begin
                state <= PARITY;
            end
        end
    end

    // Data path carries no reset; hold_valid and state qualify everything it holds.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            hold <= i_word;
        end
        if (load) begin
            sreg <= hold;
            par  <= ^hold;
        end else if (state == SHIFT && i_ce) begin
            sreg <= sreg >> 1;
        end
    end
endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: one plain instance and one with parity, checked against
// a word-level bit-stream model built from each accepted word.
module tb_word_serializer;
    logic       clk = 1'b0;
    logic       rst;
    logic       a_stb, a_ce, a_ready, a_oce, a_bit, a_last, a_idle;
    logic [7:0] a_word;
    logic       b_stb, b_ce, b_ready, b_oce, b_bit, b_last, b_idle;
    logic [7:0] b_word;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ce_mode = 0;

    logic [1:0] a_obs[$];
    int         a_obs_cyc[$];
    logic [1:0] a_exp[$];
    int         a_ce_cyc[$];
    logic [1:0] b_obs[$];
    logic [1:0] b_exp[$];

    always #5 clk = ~clk;

    word_serializer #(.LW(8), .OPT_PARITY(0)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_stb(a_stb), .i_word(a_word), .o_ready(a_ready),
        .i_ce(a_ce), .o_ce(a_oce), .o_bit(a_bit), .o_last(a_last), .o_idle(a_idle)
    );

    word_serializer #(.LW(8), .OPT_PARITY(1)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_stb(b_stb), .i_word(b_word), .o_ready(b_ready),
        .i_ce(b_ce), .o_ce(b_oce), .o_bit(b_bit), .o_last(b_last), .o_idle(b_idle)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_ce) a_ce_cyc.push_back(cyc + 1);
    end

    always @(negedge clk) begin
        if (a_oce) begin
            a_obs.push_back({a_last, a_bit});
            a_obs_cyc.push_back(cyc);
        end
        if (b_oce) b_obs.push_back({b_last, b_bit});
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (ce_mode == 1) begin
            a_ce = (cyc % 3 == 0);
            b_ce = a_ce;
        end else if (ce_mode == 2) begin
            a_ce = 1'($urandom_range(0, 1));
            b_ce = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic clear_q();
        a_obs.delete(); a_obs_cyc.delete(); a_exp.delete(); a_ce_cyc.delete();
        b_obs.delete(); b_exp.delete();
    endtask

    // Offer a word until taken; the model appends its frame to the expected stream.
    task automatic send_a(input logic [7:0] w, output int acc);
        acc = -1;
        a_stb = 1'b1;
        a_word = w;
        for (int i = 0; i < 300; i++) begin
            if (a_ready === 1'b1) begin
                tick();
                acc = cyc;
                for (int k = 0; k < 8; k++) a_exp.push_back({k == 7, w[k]});
                break;
            end
            tick();
        end
        a_stb = 1'b0;
        a_word = 8'($urandom);
        tests++;
        if (acc < 0) begin
            fails++;
            $display("FAIL send_a_timeout word %h never accepted", w);
        end
    endtask

    task automatic send_b(input logic [7:0] w);
        int acc;
        acc = -1;
        b_stb = 1'b1;
        b_word = w;
        for (int i = 0; i < 300; i++) begin
            if (b_ready === 1'b1) begin
                tick();
                acc = cyc;
                for (int k = 0; k < 8; k++) b_exp.push_back({1'b0, w[k]});
                b_exp.push_back({1'b1, ^w});
                break;
            end
            tick();
        end
        b_stb = 1'b0;
        b_word = 8'($urandom);
        tests++;
        if (acc < 0) begin
            fails++;
            $display("FAIL send_b_timeout word %h never accepted", w);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 800 && (a_obs.size() < a_exp.size() || b_obs.size() < b_exp.size()); i++) tick();
        repeat (12) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_stb = 0; a_ce = 0; a_word = 0;
        b_stb = 0; b_ce = 0; b_word = 0;
        repeat (3) tick();
        tests++;
        if ({a_ready, a_oce, a_bit, a_last, a_idle} !== 5'b10001) begin
            fails++;
            $display("FAIL reset_a got %b want 10001", {a_ready, a_oce, a_bit, a_last, a_idle});
        end
        tests++;
        if ({b_ready, b_oce, b_bit, b_last, b_idle} !== 5'b10001) begin
            fails++;
            $display("FAIL reset_b got %b want 10001", {b_ready, b_oce, b_bit, b_last, b_idle});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_a5();
        int acc;
        clear_q();
        ce_mode = 0;
        a_ce = 1'b1;
        send_a(8'hA5, acc);
        for (int i = 0; i < 40 && a_obs.size() < 8; i++) tick();
        tests++;
        if (a_idle !== 1'b1) begin
            fails++;
            $display("FAIL a5_idle_after_last got %b want 1", a_idle);
        end
        repeat (10) tick();
        tests++;
        if (a_obs.size() != 8) begin
            fails++;
            $display("FAIL a5_count got %0d want 8", a_obs.size());
        end
        for (int i = 0; i < 8 && i < a_obs.size(); i++) begin
            tests++;
            if (a_obs[i] !== a_exp[i] || a_obs_cyc[i] != acc + 2 + i) begin
                fails++;
                $display("FAIL a5_bit%0d got last/bit %b at cycle %0d want %b at cycle %0d",
                         i, a_obs[i], a_obs_cyc[i], a_exp[i], acc + 2 + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        clear_q();
        ce_mode = 0;
        a_ce = 1'b1;
        send_a(8'h01, acc);
        send_a(8'h80, acc);
        for (int n = 0; n < 6; n++) send_a(8'($urandom), acc);
        drain();
        tests++;
        if (a_obs.size() != a_exp.size()) begin
            fails++;
            $display("FAIL b2b_count got %0d want %0d", a_obs.size(), a_exp.size());
        end
        for (int i = 0; i < a_obs.size() && i < a_exp.size(); i++) begin
            tests++;
            if (a_obs[i] !== a_exp[i] || a_obs_cyc[i] != a_obs_cyc[0] + i) begin
                fails++;
                $display("FAIL b2b_bit%0d got %b at cycle %0d want %b at cycle %0d",
                         i, a_obs[i], a_obs_cyc[i], a_exp[i], a_obs_cyc[0] + i);
            end
        end
    endtask

    task automatic test_slow_ce();
        int   acc;
        logic held;
        bit   have;
        bit   found;
        clear_q();
        have = 0;
        held = 1'b0;
        ce_mode = 1;
        send_a(8'h3C, acc);
        ce_mode = 2;
        for (int n = 0; n < 4; n++) send_a(8'($urandom), acc);
        for (int i = 0; i < 600 && a_obs.size() < a_exp.size(); i++) begin
            tick();
            if (a_oce === 1'b1) begin
                held = a_bit;
                have = 1;
            end else if (have) begin
                tests++;
                if (a_bit !== held) begin
                    fails++;
                    $display("FAIL slow_bit_stable got %b want %b", a_bit, held);
                end
            end
        end
        repeat (12) tick();
        ce_mode = 0;
        tests++;
        if (a_obs.size() != a_exp.size()) begin
            fails++;
            $display("FAIL slow_count got %0d want %0d", a_obs.size(), a_exp.size());
        end
        for (int i = 0; i < a_obs.size() && i < a_exp.size(); i++) begin
            found = 0;
            foreach (a_ce_cyc[j]) if (a_ce_cyc[j] == a_obs_cyc[i]) found = 1;
            tests++;
            if (a_obs[i] !== a_exp[i] || !found) begin
                fails++;
                $display("FAIL slow_bit%0d got %b ce_before=%0d want %b ce_before=1",
                         i, a_obs[i], found, a_exp[i]);
            end
        end
    endtask

    task automatic test_parity();
        clear_q();
        ce_mode = 0;
        b_ce = 1'b1;
        send_b(8'h07);
        send_b(8'h03);
        ce_mode = 2;
        for (int n = 0; n < 4; n++) send_b(8'($urandom));
        drain();
        ce_mode = 0;
        tests++;
        if (b_obs.size() != 54) begin
            fails++;
            $display("FAIL par_count got %0d want 54", b_obs.size());
        end
        if (b_obs.size() >= 18) begin
            tests++;
            if (b_obs[8] !== 2'b11 || b_obs[17] !== 2'b10) begin
                fails++;
                $display("FAIL par_fixed got %b,%b want 11,10", b_obs[8], b_obs[17]);
            end
        end
        for (int i = 0; i < b_obs.size() && i < b_exp.size(); i++) begin
            tests++;
            if (b_obs[i] !== b_exp[i]) begin
                fails++;
                $display("FAIL par_bit%0d got %b want %b", i, b_obs[i], b_exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        int acc1, acc2, acc3;
        logic [7:0] w1, w2, w3;
        clear_q();
        ce_mode = 0;
        a_ce = 1'b0;
        w1 = 8'($urandom); w2 = 8'($urandom); w3 = 8'($urandom);
        send_a(w1, acc1);
        send_a(w2, acc2);
        a_stb = 1'b1;
        a_word = w3;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (a_ready !== 1'b0 || a_oce !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold got ready=%b oce=%b want ready=0 oce=0", a_ready, a_oce);
            end
        end
        a_ce = 1'b1;
        send_a(w3, acc3);
        drain();
        tests++;
        if (a_obs.size() != 24) begin
            fails++;
            $display("FAIL stall_count got %0d want 24", a_obs.size());
        end
        if (a_obs.size() >= 8) begin
            tests++;
            if (acc3 <= a_obs_cyc[7]) begin
                fails++;
                $display("FAIL stall_third_early got accept cycle %0d want after %0d", acc3, a_obs_cyc[7]);
            end
        end
        for (int i = 0; i < a_obs.size() && i < a_exp.size(); i++) begin
            tests++;
            if (a_obs[i] !== a_exp[i]) begin
                fails++;
                $display("FAIL stall_bit%0d got %b want %b", i, a_obs[i], a_exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int n;
        clear_q();
        ce_mode = 0;
        a_ce = 1'b1;
        send_a(8'hFF, acc);
        n = (a_oce === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            tick();
            if (a_oce === 1'b1) n++;
        end
        tests++;
        if (n != 3) begin
            fails++;
            $display("FAIL rmid_bits got %0d want 3", n);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({a_ready, a_oce, a_bit, a_last, a_idle} !== 5'b10001) begin
            fails++;
            $display("FAIL rmid_async got %b want 10001", {a_ready, a_oce, a_bit, a_last, a_idle});
        end
        tick();
        rst = 1'b0;
        tick();
        clear_q();
        send_a(8'h5A, acc);
        drain();
        tests++;
        if (a_obs.size() != 8) begin
            fails++;
            $display("FAIL rmid_count got %0d want 8", a_obs.size());
        end
        for (int i = 0; i < a_obs.size() && i < a_exp.size(); i++) begin
            tests++;
            if (a_obs[i] !== a_exp[i]) begin
                fails++;
                $display("FAIL rmid_bit%0d got %b want %b", i, a_obs[i], a_exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_slow_ce();
        test_parity();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
